// File: rtl/packer_feeder_pkg.sv
// Shared types and helpers for the packer feeder slice.
// Exports the element type, default element width and a ceil-log2 helper.
package packer_feeder_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef logic [DATA_WIDTH_DEF-1:0] elem_t;

    // Same ceil-log2 as the packer, so both ends size indices alike.
    function automatic int log2c(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/packer_feeder_word_fifo.sv
// word_fifo: generic synchronous FIFO with flush.
// Ports: clk, rst, i_flush, i_push, i_pop, i_dat -> o_full, o_empty, o_head.
module word_fifo
    import packer_feeder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PW = log2c(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rd];

    // Flush wins over both operations in the same cycle.
    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr] <= i_dat;
        end
    end

    // Pointers wrap modulo DEPTH through natural overflow.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/packer_feeder.sv
// packer_feeder: buffers wide words and serves them MSB element first.
// Ports: clk, rst, Flush, InVld/InRdy/InDat in; ReqDat -> ValDat/Dat, Empty.
module packer_feeder
    import packer_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_IN     = 16,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Flush,
    input  logic                         InVld,
    output logic                         InRdy,
    input  logic [DATA_WIDTH*NUM_IN-1:0] InDat,
    input  logic                         ReqDat,
    output logic                         ValDat,
    output logic [DATA_WIDTH-1:0]        Dat,
    output logic                         Empty
);

    localparam int WW = DATA_WIDTH * NUM_IN;
    localparam int IW = log2c(NUM_IN);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_IN - 1);

    logic                  w_full;
    logic                  w_empty;
    logic [WW-1:0]         w_head;
    logic                  w_serve;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_elems [NUM_IN];
    logic [IW-1:0]         r_idx;
    logic                  r_val;
    logic [DATA_WIDTH-1:0] r_dat;

    assign InRdy   = !w_full;
    assign Empty   = w_empty;
    assign ValDat  = r_val;
    assign Dat     = r_dat;
    assign w_serve = ReqDat && !w_empty;
    // Head word retires with its last (least significant) element.
    assign w_pop   = w_serve && (r_idx == '0);

    for (genvar g = 0; g < NUM_IN; g++) begin : g_elem
        assign w_elems[g] = w_head[g*DATA_WIDTH +: DATA_WIDTH];
    end

    word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (Flush),
        .i_push  (InVld),
        .i_pop   (w_pop),
        .i_dat   (InDat),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Dat holds across idle and flush cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= IDX_MAX;
            r_val <= 1'b0;
            r_dat <= '0;
        end else if (Flush) begin
            r_idx <= IDX_MAX;
            r_val <= 1'b0;
        end else begin
            r_val <= w_serve;
            if (w_serve) begin
                r_dat <= w_elems[r_idx];
                r_idx <= r_idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packer_feeder.sv
// Directed and random stimulus with a scoreboard of expected elements.
module tb_packer_feeder;

    localparam int DW    = 8;
    localparam int NI    = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             Flush = 1'b0;
    logic             InVld = 1'b0;
    logic             InRdy;
    logic [DW*NI-1:0] InDat = '0;
    logic             ReqDat = 1'b0;
    logic             ValDat;
    logic [DW-1:0]    Dat;
    logic             Empty;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_dat = '0;
    bit            last_acc;
    int            n_chk  = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    packer_feeder #(
        .DATA_WIDTH (DW),
        .NUM_IN     (NI),
        .DEPTH      (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .Flush  (Flush),
        .InVld  (InVld),
        .InRdy  (InRdy),
        .InDat  (InDat),
        .ReqDat (ReqDat),
        .ValDat (ValDat),
        .Dat    (Dat),
        .Empty  (Empty)
    );

    function automatic int words_m();
        return (sb.size() + NI - 1) / NI;
    endfunction

    function automatic logic [DW*NI-1:0] mk_word(input int base);
        logic [DW*NI-1:0] w;
        w = '0;
        for (int i = 0; i < NI; i++) w[i*DW +: DW] = DW'(base + i);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    // One clock with model update and full output check.
    task automatic cyc();
        bit acc;
        bit srv;
        acc = InVld && (words_m() < DEPTH) && !Flush && !rst;
        srv = ReqDat && (sb.size() != 0) && !Flush && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            exp_dat = '0;
        end else if (Flush) begin
            sb.delete();
        end
        if (srv) exp_dat = sb.pop_front();
        if (acc) begin
            for (int k = NI - 1; k >= 0; k--) sb.push_back(InDat[k*DW +: DW]);
        end
        last_acc = acc;
        chk("ValDat", 32'(ValDat), 32'(srv));
        chk("Dat", 32'(Dat), 32'(exp_dat));
        chk("Empty", 32'(Empty), 32'(sb.size() == 0));
        chk("InRdy", 32'(InRdy), 32'(words_m() < DEPTH));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        // Reset state
        cycles(2);
        rst = 1'b0;
        cyc();

        // One word, 16 back-to-back requests
        InVld = 1'b1;
        InDat = mk_word(0);
        cyc();
        InVld = 1'b0;
        ReqDat = 1'b1;
        cycles(17);

        // Requests held while empty, then a push
        cycles(5);
        InVld = 1'b1;
        InDat = mk_word(8'h20);
        cyc();
        InVld = 1'b0;
        cycles(18);
        ReqDat = 1'b0;
        cyc();

        // Fill past DEPTH with no requests
        for (int w = 0; w < 4; w++) begin
            InVld = 1'b1;
            InDat = mk_word(8'h40 + 16 * w);
            cyc();
        end
        InDat = mk_word(8'h80);
        cycles(3);
        chk("held5", 32'(last_acc), 32'(0));
        ReqDat = 1'b1;
        for (int i = 0; i < 20 && !last_acc; i++) cyc();
        chk("acc5", 32'(last_acc), 32'(1));
        InVld = 1'b0;
        cycles(70);
        ReqDat = 1'b0;
        cyc();

        // Flush after a partial word
        InVld = 1'b1;
        InDat = mk_word(8'hA0);
        cyc();
        InVld = 1'b0;
        ReqDat = 1'b1;
        cycles(3);
        Flush = 1'b1;
        InVld = 1'b1;
        InDat = mk_word(8'hC0);
        cyc();
        Flush = 1'b0;
        InVld = 1'b0;
        cyc();
        InVld = 1'b1;
        InDat = mk_word(8'hD0);
        cyc();
        InVld = 1'b0;
        cycles(17);
        ReqDat = 1'b0;

        // Random concurrent push/serve
        for (int i = 0; i < 200; i++) begin
            InVld  = 1'($urandom_range(0, 1));
            ReqDat = ($urandom_range(0, 3) != 0);
            InDat  = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end

        // Reset during active service
        InVld = 1'b1;
        ReqDat = 1'b1;
        InDat = mk_word(8'h10);
        cyc();
        InVld = 1'b0;
        cycles(4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cycles(3);
        ReqDat = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/packer_feeder.md
# packer_feeder

Upstream feeder for the data packer stage. Accepts wide words from the buffer/memory side over a valid/ready handshake, stores them in a small FIFO, and serves them one DATA_WIDTH element at a time on a ReqDat/ValDat/Dat port. ValDat rises exactly one clock after the ReqDat that requested the element, which is the contract the packer relies on. Elements leave each word most-significant first, so a packer with NUM_DATA = NUM_IN rebuilds the original word bit-exact.

## Interface
- DATA_WIDTH, 8: width of one served element.
- NUM_IN, 16: elements per input word; power of two, at least 2.
- DEPTH, 4: FIFO depth in input words; power of two, at least 2.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- Flush  in  1  pulse; discards all buffered data. Issued together with the packer's Sta when a new packing job begins.
- InVld  in  1  input word valid.
- InRdy  out  1  FIFO can accept a word.
- InDat  in  DATA_WIDTH*NUM_IN  input word; element NUM_IN-1 occupies the MSBs.
- ReqDat  in  1  element request from the packer; may be held high across many cycles.
- ValDat  out  1  registered; Dat is valid in this cycle.
- Dat  out  DATA_WIDTH  registered element.
- Empty  out  1  no element available (count == 0).

## Operation
- Storage: DEPTH-entry word FIFO with write pointer, read pointer and entry count. The count is $clog2(DEPTH)+1 bits wide.
- An element index EleIdx (log2(NUM_IN) bits) selects the current element of the head word. EleIdx counts down from NUM_IN-1 to 0.
- Write: a word is accepted when InVld && InRdy. InRdy = (count < DEPTH). InRdy does not look ahead at a same-cycle pop.
- Serve: when ReqDat && !Empty in cycle t, the next edge does the following:
  - loads Dat with head-word element EleIdx (bits EleIdx*DATA_WIDTH +: DATA_WIDTH);
  - sets ValDat to 1;
  - decrements EleIdx.
- Word pop: when EleIdx == 0 is served, EleIdx wraps to NUM_IN-1, the read pointer advances, and count decrements.
- Simultaneous push and pop in one cycle leaves count unchanged, and both pointers advance.
- ReqDat && Empty: ValDat = 0 at the next edge and no state changes. The packer stays in its read state and keeps ReqDat high, so service resumes once data arrives. The first element of a newly pushed word can be served no earlier than the cycle after the push.
- When ReqDat is low, ValDat = 0 at the next edge. Dat holds its last value.
- Flush: clears both pointers and count, sets EleIdx to NUM_IN-1, and forces ValDat to 0.
  - Flush overrides a same-cycle push and a same-cycle serve.
  - A word presented in the Flush cycle is dropped, even though InRdy is high.
- A partial word (EleIdx != NUM_IN-1) remains at the head across packing jobs unless Flush is issued.
- Pointer arithmetic wraps modulo DEPTH.

## Timing
- Reset (rst high at an edge) sets: ValDat = 0, Dat = 0, InRdy = 1 (from count = 0), Empty = 1, EleIdx = NUM_IN-1, both pointers = 0.
- If rst is asserted mid-stream, outputs take these values at the next edge and buffered data is lost.
- Latency: ReqDat at t gives ValDat/Dat at t+1. Input word accepted at t gives its first element eligible for request at t+1 and visible on Dat at t+2.
- Throughput: one element per cycle while data is available; one word per cycle on input while not full.
- No state machine is needed. Behaviour is fully determined by count, pointers and EleIdx.
- Combinational outputs: InRdy and Empty only. ValDat and Dat are flops.

## Structure
- Shared package: element type, DATA_WIDTH default, and a log2 helper matching the one the packer uses.
- Natural sub-module: `word_fifo`. It is a generic synchronous FIFO with DEPTH, a width parameter, push, pop, full, empty and head outputs.
- `packer_feeder` wraps `word_fifo` and adds EleIdx, the element mux, and the ValDat/Dat registers.

## Test plan
- Reset, then push one word 0x0F0E…0100 (NUM_IN=16, element i = i) and hold ReqDat for 16 cycles. Required: ValDat high for cycles 1–16 after the first request, with Dat = 0x0F, 0x0E, …, 0x00. Empty rises after the last element is served.
- Hold ReqDat high with the FIFO empty for 5 cycles, then push one word. Required: ValDat stays 0 until two cycles after the push, then one element per cycle with no gaps.
- Push 5 words with no requests while DEPTH=4. Required: InRdy drops after the 4th accept and the 5th is held. After 16 serves InRdy rises and the 5th word is accepted.
- Push a word and serve 3 elements, then assert Flush with InVld high. Required: the next cycle has ValDat=0 and Empty=1. The word from the Flush cycle is absent, and the next pushed word begins at element 15.
- Push and serve continuously for 200 cycles at DEPTH=4. Required: count never exceeds 4, and the served sequence equals the pushed elements in MSB-first order with no loss or duplication across pointer wrap.
- Assert rst during active service. Required: the next edge gives ValDat=0, Dat=0, Empty=1 and InRdy=1.
